// File: rtl/enqueue_agent_v0_2_if.sv
// enqueue_agent_v0_2 bus: AXIS ingress, per-port enables, drop-counter read port.
// master = upstream/driver side, slave = the enqueue agent.
interface enqueue_agent_v0_2_if #(
    parameter int unsigned NUM_PORTS   = 5,
    parameter int unsigned TUSER_WIDTH = 128,
    parameter int unsigned CNT_WIDTH   = 32
);
    logic                   s_axis_tvalid;
    logic                   s_axis_tready;
    logic [TUSER_WIDTH-1:0] s_axis_tuser;
    logic                   s_axis_tlast;
    logic                   s_axis_tpifo_valid;
    logic [NUM_PORTS-1:0]   s_axis_buffer_almost_full;
    logic [NUM_PORTS-1:0]   s_axis_pifo_full;
    logic                   m_axis_valid;
    logic [NUM_PORTS-1:0]   m_axis_ctl_buffer_wr_en;
    logic [NUM_PORTS-1:0]   m_axis_ctl_pifo_in_en;
    logic [4:0]             s_axi_addr;
    logic                   s_axi_req_valid;
    logic [CNT_WIDTH-1:0]   m_axi_data;
    logic                   m_axi_resp_valid;

    modport master (
        output s_axis_tvalid,
        input  s_axis_tready,
        output s_axis_tuser,
        output s_axis_tlast,
        output s_axis_tpifo_valid,
        output s_axis_buffer_almost_full,
        output s_axis_pifo_full,
        input  m_axis_valid,
        input  m_axis_ctl_buffer_wr_en,
        input  m_axis_ctl_pifo_in_en,
        output s_axi_addr,
        output s_axi_req_valid,
        input  m_axi_data,
        input  m_axi_resp_valid
    );

    modport slave (
        input  s_axis_tvalid,
        output s_axis_tready,
        input  s_axis_tuser,
        input  s_axis_tlast,
        input  s_axis_tpifo_valid,
        input  s_axis_buffer_almost_full,
        input  s_axis_pifo_full,
        output m_axis_valid,
        output m_axis_ctl_buffer_wr_en,
        output m_axis_ctl_pifo_in_en,
        input  s_axi_addr,
        input  s_axi_req_valid,
        output m_axi_data,
        output m_axi_resp_valid
    );
endinterface

// File: rtl/enqueue_agent_v0_2.sv
// enqueue_agent_v0_2: per-packet multicast admission, buffer write and PIFO insert enables.
// Optional drop counters enabled by defining ENQ_DROP_CNT_EN.
module enqueue_agent_v0_2 #(
    parameter int unsigned NUM_PORTS    = 5,
    parameter int unsigned TUSER_WIDTH  = 128,
    parameter int unsigned DST_OFFSET   = 24,
    parameter int unsigned DROP_ON_FULL = 1,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input logic           axis_aclk,
    input logic           axis_resetn,
    enqueue_agent_v0_2_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_PORTS-1:0] pass;
    logic [NUM_PORTS-1:0] dst;
    logic [NUM_PORTS-1:0] blocked;
    logic [NUM_PORTS-1:0] sop_pass;
    logic [NUM_PORTS-1:0] wr_en_q;
    logic [NUM_PORTS-1:0] pifo_en_q;
    logic                 valid_q;
    logic                 ready;
    logic                 beat;
    logic                 resp_q;
    logic                 unused_tuser;

    assign dst     = bus.s_axis_tuser[DST_OFFSET +: NUM_PORTS];
    assign blocked = bus.s_axis_buffer_almost_full
                   | bus.s_axis_pifo_full;

    // Only the destination field of tuser is consumed.
    assign unused_tuser = ^bus.s_axis_tuser;

    // Drop mode filters full ports at SOP; stall mode keeps the full mask.
    generate
        if (DROP_ON_FULL != 0) begin : g_drop
            assign sop_pass = dst & ~blocked;
            assign ready    = axis_resetn;
        end else begin : g_stall
            assign sop_pass = dst;
            assign ready    = axis_resetn
                            & ((state != IDLE) | ~|(dst & blocked));
        end
    endgenerate

    assign beat              = bus.s_axis_tvalid & ready;
    assign bus.s_axis_tready = ready;

    assign bus.m_axis_valid            = valid_q;
    assign bus.m_axis_ctl_buffer_wr_en = wr_en_q;
    assign bus.m_axis_ctl_pifo_in_en   = pifo_en_q;
    assign bus.m_axi_resp_valid        = resp_q;

    // Packet FSM with registered enables, one cycle behind the beat.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state     <= IDLE;
            pass      <= '0;
            wr_en_q   <= '0;
            pifo_en_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            wr_en_q   <= '0;
            pifo_en_q <= '0;
            valid_q   <= 1'b0;
            if (beat) begin
                unique case (state)
                    IDLE: begin
                        pass <= sop_pass;
                        if (|sop_pass) begin
                            wr_en_q <= sop_pass;
                            valid_q <= 1'b1;
                            if (bus.s_axis_tlast) begin
                                if (bus.s_axis_tpifo_valid)
                                    pifo_en_q <= sop_pass;
                            end else begin
                                state <= FWD;
                            end
                        end else if (!bus.s_axis_tlast) begin
                            state <= DROP;
                        end
                    end
                    FWD: begin
                        wr_en_q <= pass;
                        valid_q <= 1'b1;
                        if (bus.s_axis_tlast) begin
                            if (bus.s_axis_tpifo_valid)
                                pifo_en_q <= pass;
                            state <= IDLE;
                        end
                    end
                    DROP: begin
                        if (bus.s_axis_tlast)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef ENQ_DROP_CNT_EN
    logic [NUM_PORTS-1:0] dropped;
    logic [CNT_WIDTH-1:0] cnt [NUM_PORTS];
    logic [CNT_WIDTH-1:0] rd_data;
    logic [CNT_WIDTH-1:0] data_q;

    // A port counts as dropped only on an accepted SOP in drop mode.
    assign dropped = (DROP_ON_FULL != 0 && beat && state == IDLE)
                   ? (dst & blocked) : '0;

    // Saturating per-port drop counters.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            for (int p = 0; p < NUM_PORTS; p++)
                cnt[p] <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++)
                if (dropped[p] && !(&cnt[p]))
                    cnt[p] <= cnt[p] + 1'b1;
        end
    end

    // Address decode; out-of-range ports read as zero.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (bus.s_axi_addr == 5'(p))
                rd_data = cnt[p];
    end

    // Read response, returning the pre-increment counter value.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            resp_q <= 1'b0;
            data_q <= '0;
        end else begin
            resp_q <= bus.s_axi_req_valid;
            data_q <= bus.s_axi_req_valid ? rd_data : '0;
        end
    end

    assign bus.m_axi_data = data_q;
`else
    logic unused_addr;

    assign unused_addr    = ^bus.s_axi_addr;
    assign bus.m_axi_data = '0;

    // Without counters the read port still acknowledges requests.
    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn)
            resp_q <= 1'b0;
        else
            resp_q <= bus.s_axi_req_valid;
    end
`endif

endmodule

// File: tb/tb_enqueue_agent_v0_2.sv
// Directed bench for enqueue_agent_v0_2: drop-mode and stall-mode instances.
// Expected enables are queued at each beat and compared one cycle later.
module tb_enqueue_agent_v0_2;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [9:0] exp_q [$];

`ifdef ENQ_DROP_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    enqueue_agent_v0_2_if #(.NUM_PORTS(5), .TUSER_WIDTH(128), .CNT_WIDTH(32)) bus_a ();
    enqueue_agent_v0_2_if #(.NUM_PORTS(5), .TUSER_WIDTH(128), .CNT_WIDTH(32)) bus_b ();

    enqueue_agent_v0_2 #(.NUM_PORTS(5), .DROP_ON_FULL(1)) u_drop (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .bus         (bus_a)
    );

    enqueue_agent_v0_2 #(.NUM_PORTS(5), .DROP_ON_FULL(0)) u_stall (
        .axis_aclk   (clk),
        .axis_resetn (rst_n),
        .bus         (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle on bus A (b=0) or bus B (b=1); the other bus idles.
    task automatic step(input bit b, input bit v, input bit l, input bit pv,
                        input logic [4:0] dst, input logic [4:0] af, input logic [4:0] pf,
                        input bit erdy, input logic [4:0] ew, input logic [4:0] ep);
        logic [9:0]   e;
        logic [127:0] tu;
        tu = {123'b0, dst} << 24;
        bus_a.s_axis_tvalid = v & ~b;
        bus_b.s_axis_tvalid = v & b;
        bus_a.s_axis_tlast = l;
        bus_b.s_axis_tlast = l;
        bus_a.s_axis_tpifo_valid = pv;
        bus_b.s_axis_tpifo_valid = pv;
        bus_a.s_axis_tuser = tu;
        bus_b.s_axis_tuser = tu;
        bus_a.s_axis_buffer_almost_full = af;
        bus_b.s_axis_buffer_almost_full = af;
        bus_a.s_axis_pifo_full = pf;
        bus_b.s_axis_pifo_full = pf;
        #1;
        chk("tready", b ? bus_b.s_axis_tready : bus_a.s_axis_tready, 32'(erdy));
        @(posedge clk);
        exp_q.push_back({ew, ep});
        @(negedge clk);
        e = exp_q.pop_front();
        if (b) begin
            chk("wr_en_b", bus_b.m_axis_ctl_buffer_wr_en, 32'(e[9:5]));
            chk("pifo_b", bus_b.m_axis_ctl_pifo_in_en, 32'(e[4:0]));
            chk("valid_b", bus_b.m_axis_valid, 32'(|e));
        end else begin
            chk("wr_en_a", bus_a.m_axis_ctl_buffer_wr_en, 32'(e[9:5]));
            chk("pifo_a", bus_a.m_axis_ctl_pifo_in_en, 32'(e[4:0]));
            chk("valid_a", bus_a.m_axis_valid, 32'(|e));
        end
    endtask

    task automatic rd(input logic [4:0] addr, input logic [31:0] exp);
        bus_a.s_axis_tvalid = 1'b0;
        bus_b.s_axis_tvalid = 1'b0;
        bus_a.s_axi_addr = addr;
        bus_a.s_axi_req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus_a.s_axi_req_valid = 1'b0;
        #1;
        chk("resp_valid", bus_a.m_axi_resp_valid, 32'd1);
        chk("cnt_data", bus_a.m_axi_data, exp);
        @(posedge clk);
        @(negedge clk);
        chk("resp_pulse", bus_a.m_axi_resp_valid, 32'd0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n = 1'b0;
        bus_a.s_axis_tvalid = 0;
        bus_a.s_axis_tuser = '0;
        bus_a.s_axis_tlast = 0;
        bus_a.s_axis_tpifo_valid = 0;
        bus_a.s_axis_buffer_almost_full = '0;
        bus_a.s_axis_pifo_full = '0;
        bus_a.s_axi_addr = '0;
        bus_a.s_axi_req_valid = 0;
        bus_b.s_axis_tvalid = 0;
        bus_b.s_axis_tuser = '0;
        bus_b.s_axis_tlast = 0;
        bus_b.s_axis_tpifo_valid = 0;
        bus_b.s_axis_buffer_almost_full = '0;
        bus_b.s_axis_pifo_full = '0;
        bus_b.s_axi_addr = '0;
        bus_b.s_axi_req_valid = 0;
        repeat (2) @(negedge clk);
        bus_a.s_axis_tvalid = 1;
        #1;
        chk("rst_tready_a", bus_a.s_axis_tready, 0);
        chk("rst_tready_b", bus_b.s_axis_tready, 0);
        chk("rst_valid", bus_a.m_axis_valid, 0);
        chk("rst_wr_en", bus_a.m_axis_ctl_buffer_wr_en, 0);
        chk("rst_data", bus_a.m_axi_data, 0);
        chk("rst_resp", bus_a.m_axi_resp_valid, 0);
        bus_a.s_axis_tvalid = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // 3-beat multicast, nothing full
        step(0, 1, 0, 1, 5'b00101, 0, 0, 1, 5'b00101, 0);
        step(0, 1, 0, 1, 5'b00101, 0, 0, 1, 5'b00101, 0);
        step(0, 1, 1, 1, 5'b00101, 0, 0, 1, 5'b00101, 5'b00101);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // partial drop on almost-full port 1
        step(0, 1, 0, 1, 5'b00110, 5'b00010, 0, 1, 5'b00100, 0);
        step(0, 1, 1, 1, 5'b00110, 5'b00010, 0, 1, 5'b00100, 5'b00100);
        rd(5'd1, CNT_ON ? 32'd1 : 32'd0);

        // full drop via pifo_full, full clears mid-packet
        step(0, 1, 0, 1, 5'b00010, 0, 5'b00010, 1, 0, 0);
        step(0, 1, 0, 1, 5'b00010, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 5'b00010, 0, 0, 1, 0, 0);
        step(0, 1, 1, 1, 5'b00010, 0, 0, 1, 0, 0);
        step(0, 1, 0, 1, 5'b00001, 0, 0, 1, 5'b00001, 0);
        step(0, 1, 1, 1, 5'b00001, 0, 0, 1, 5'b00001, 5'b00001);
        rd(5'd1, CNT_ON ? 32'd2 : 32'd0);
        rd(5'd0, 32'd0);
        rd(5'd7, 32'd0);

        // dst==0 dropped without touching counters
        step(0, 1, 0, 1, 5'b00000, 5'b11111, 0, 1, 0, 0);
        step(0, 1, 1, 1, 5'b00000, 0, 0, 1, 0, 0);
        rd(5'd1, CNT_ON ? 32'd2 : 32'd0);
        rd(5'd2, 32'd0);

        // single-beat packets with and without descriptor
        step(0, 1, 1, 0, 5'b01000, 0, 0, 1, 5'b01000, 0);
        step(0, 1, 1, 1, 5'b10000, 0, 0, 1, 5'b10000, 5'b10000);
        step(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // tvalid gap mid-packet keeps FWD state
        step(0, 1, 0, 1, 5'b00011, 0, 0, 1, 5'b00011, 0);
        step(0, 0, 0, 1, 5'b00000, 5'b11111, 0, 1, 0, 0);
        step(0, 1, 1, 1, 5'b00000, 5'b11111, 0, 1, 5'b00011, 5'b00011);

        // stall mode: SOP held for 6 cycles, then mid-packet full ignored
        for (int i = 0; i < 6; i++)
            step(1, 1, 0, 1, 5'b00001, 5'b00001, 0, 0, 0, 0);
        step(1, 1, 0, 1, 5'b00001, 0, 0, 1, 5'b00001, 0);
        step(1, 1, 0, 1, 5'b00001, 5'b00001, 0, 1, 5'b00001, 0);
        step(1, 1, 1, 1, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 5'b00001);
        step(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // reset on beat 2 of 4
        step(0, 1, 0, 1, 5'b00011, 0, 0, 1, 5'b00011, 0);
        bus_a.s_axis_tvalid = 1'b1;
        bus_a.s_axis_tlast = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wr_en", bus_a.m_axis_ctl_buffer_wr_en, 0);
        chk("mid_rst_valid", bus_a.m_axis_valid, 0);
        chk("mid_rst_tready", bus_a.s_axis_tready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 1, 5'b00100, 0, 0, 1, 5'b00100, 0);
        step(0, 1, 1, 1, 5'b00100, 0, 0, 1, 5'b00100, 5'b00100);
        rd(5'd1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
